// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared opcode constants, FSM state codes and decode helpers for the hazard controller.
// The state codes are visible to software through o_state, so their values are fixed.
package pipeline_hazard_ctrl_pkg;

  localparam logic [6:0] L_OP     = 7'b0000011;
  localparam logic [6:0] S_OP     = 7'b0100011;
  localparam logic [6:0] B_OP     = 7'b1100011;
  localparam logic [6:0] R_OP     = 7'b0110011;
  localparam logic [6:0] LUI_OP   = 7'b0110111;
  localparam logic [6:0] AUIPC_OP = 7'b0010111;
  localparam logic [6:0] JAL_OP   = 7'b1101111;
  localparam logic [6:0] SYS_OP   = 7'b1110011;

  typedef enum logic [2:0] {
    HZ_RUN       = 3'd0,
    HZ_FLUSH     = 3'd1,
    HZ_CSR_DRAIN = 3'd2,
    HZ_CSR_ISSUE = 3'd3,
    HZ_MEM_WAIT  = 3'd4
  } hz_state_e;

  // ECALL/EBREAK/MRET share SYS_OP with funct3==0 and need no serialisation.
  function automatic logic is_csr_op(input logic [6:0] opcode, input logic [2:0] funct3);
    return (opcode == SYS_OP) && (funct3 != 3'd0);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Load-use hazard detection: a load in EX whose rd is a source of the instruction in decode.
// Purely combinational; x0 is never a hazard.
module load_use_detect
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [6:0] id_opcode,
  input  logic [4:0] id_rs1_addr,
  input  logic [4:0] id_rs2_addr,
  input  logic [6:0] ex_opcode,
  input  logic [4:0] ex_rd_addr,
  output logic       hazard
);

  logic [1:0] src_used;
  logic [1:0] src_hit;
  logic [4:0] src_addr [2];

  // Only U-type and JAL ignore rs1; only R/S/B read rs2.
  assign src_used[0] = !((id_opcode == LUI_OP) || (id_opcode == AUIPC_OP) || (id_opcode == JAL_OP));
  assign src_used[1] = (id_opcode == R_OP) || (id_opcode == S_OP) || (id_opcode == B_OP);
  assign src_addr[0] = id_rs1_addr;
  assign src_addr[1] = id_rs2_addr;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      assign src_hit[gi] = src_used[gi] && (src_addr[gi] == ex_rd_addr);
    end
  endgenerate

  assign hazard = (ex_opcode == L_OP) && (ex_rd_addr != 5'd0) && (|src_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: redirect flush window, CSR drain,
// data-memory freeze with state save/restore, and load-use bubbles.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CNT_W        = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [6:0] i_id_opcode,
  input  logic [2:0] i_id_funct3,
  input  logic [4:0] i_id_rs1_addr,
  input  logic [4:0] i_id_rs2_addr,
  input  logic [6:0] i_ex_opcode,
  input  logic [4:0] i_ex_rd_addr,
  input  logic       i_redirect,
  input  logic       i_trap,
  input  logic       i_mem_busy,
  output logic       o_pc_hold,
  output logic       o_if_hold,
  output logic       o_id_stall,
  output logic       o_id_flush,
  output logic       o_if_flush,
  output logic       o_ex_hold,
  output logic       o_csr_issue,
  output logic [2:0] o_state
);

  localparam logic [CNT_W-1:0] FLUSH_LOAD = (FLUSH_CYCLES > 1) ? CNT_W'(FLUSH_CYCLES - 2) : '0;
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

  hz_state_e        state_reg, state_next;
  hz_state_e        saved_state_reg, saved_state_next;
  hz_state_e        eval_state;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] saved_cnt_reg, saved_cnt_next;
  logic [CNT_W-1:0] eval_cnt;
  logic             load_use;
  logic             csr_detect;

  load_use_detect u_load_use (
    .id_opcode   (i_id_opcode),
    .id_rs1_addr (i_id_rs1_addr),
    .id_rs2_addr (i_id_rs2_addr),
    .ex_opcode   (i_ex_opcode),
    .ex_rd_addr  (i_ex_rd_addr),
    .hazard      (load_use)
  );

  assign csr_detect = is_csr_op(i_id_opcode, i_id_funct3);
  assign o_state    = state_reg;

  // The cycle memory completes is evaluated as the state the freeze interrupted.
  always_comb begin
    eval_state = state_reg;
    eval_cnt   = cnt_reg;
    if (state_reg == HZ_MEM_WAIT) begin
      eval_state = saved_state_reg;
      eval_cnt   = saved_cnt_reg;
    end
  end

  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    saved_state_next = saved_state_reg;
    saved_cnt_next   = saved_cnt_reg;
    o_pc_hold        = 1'b0;
    o_if_hold        = 1'b0;
    o_id_stall       = 1'b0;
    o_id_flush       = 1'b0;
    o_if_flush       = 1'b0;
    o_ex_hold        = 1'b0;
    o_csr_issue      = 1'b0;

    if (i_trap || i_redirect) begin
      o_id_flush = 1'b1;
      o_if_flush = 1'b1;
      if (FLUSH_CYCLES == 1) begin
        state_next = HZ_RUN;
        cnt_next   = '0;
      end else begin
        state_next = HZ_FLUSH;
        cnt_next   = FLUSH_LOAD;
      end
    end else if (i_mem_busy) begin
      o_pc_hold  = 1'b1;
      o_if_hold  = 1'b1;
      o_ex_hold  = 1'b1;
      state_next = HZ_MEM_WAIT;
      if (state_reg != HZ_MEM_WAIT) begin
        saved_state_next = state_reg;
        saved_cnt_next   = cnt_reg;
      end
    end else begin
      unique case (eval_state)
        HZ_FLUSH: begin
          o_id_flush = 1'b1;
          o_if_flush = 1'b1;
          if (eval_cnt == '0) begin
            state_next = HZ_RUN;
            cnt_next   = eval_cnt;
          end else begin
            state_next = HZ_FLUSH;
            cnt_next   = eval_cnt - CNT_W'(1);
          end
        end
        HZ_CSR_DRAIN: begin
          o_pc_hold  = 1'b1;
          o_if_hold  = 1'b1;
          o_id_stall = 1'b1;
          if (eval_cnt == '0) begin
            state_next = HZ_CSR_ISSUE;
            cnt_next   = eval_cnt;
          end else begin
            state_next = HZ_CSR_DRAIN;
            cnt_next   = eval_cnt - CNT_W'(1);
          end
        end
        HZ_CSR_ISSUE: begin
          o_csr_issue = 1'b1;
          state_next  = HZ_RUN;
          cnt_next    = eval_cnt;
        end
        HZ_RUN: begin
          state_next = HZ_RUN;
          cnt_next   = eval_cnt;
          // CSR wins over load-use: the drain bubbles also cover the load.
          if (csr_detect) begin
            o_pc_hold  = 1'b1;
            o_if_hold  = 1'b1;
            o_id_stall = 1'b1;
            state_next = HZ_CSR_DRAIN;
            cnt_next   = DRAIN_LOAD;
          end else if (load_use) begin
            o_pc_hold  = 1'b1;
            o_if_hold  = 1'b1;
            o_id_stall = 1'b1;
          end
        end
        default: begin
          state_next = HZ_RUN;
          cnt_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg       <= HZ_RUN;
      cnt_reg         <= '0;
      saved_state_reg <= HZ_RUN;
      saved_cnt_reg   <= '0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      saved_state_reg <= saved_state_next;
      saved_cnt_reg   <= saved_cnt_next;
    end
  end

endmodule
